// File: rtl/riscv.sv
// Shared core types plus the boot-loader additions used by imem_loader.
package riscv;

  typedef logic [31:0] word_t;
  typedef word_t       ir_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-lane assembler: collects NUM_LANES bytes little-endian into one word.
// word shows the lanes including the byte arriving this cycle, so the caller
// can register the full word on the same cycle word_vld strobes.
module loader_word_asm #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_vld,
  input  logic [VEC_W-1:0]           in_byte,
  output logic [NUM_LANES*VEC_W-1:0] word,
  output logic                       word_vld
);

  localparam int CW = $clog2(NUM_LANES);

  logic [CW-1:0]                     lane_cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lanes;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lanes_nxt;

  // Each lane captures the incoming byte only when the lane counter points at it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes_nxt[i] = (in_vld && lane_cnt == CW'(i)) ? in_byte : lanes[i];
  end

  assign word     = lanes_nxt;
  assign word_vld = in_vld && (lane_cnt == CW'(NUM_LANES - 1));

  // Lane storage and counter; the counter wraps naturally after the last lane.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_cnt <= '0;
      lanes    <= '0;
    end else if (in_vld) begin
      lanes    <= lanes_nxt;
      lane_cnt <= lane_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses MAGIC/LEN/payload/CSUM frames,
// writes payload words from address 0 and releases the core on success.
module imem_loader
  import riscv::*;
#(
  parameter int         ADDR_WIDTH = 9,
  parameter logic [7:0] MAGIC      = LOADER_MAGIC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output word_t                 imem_data,
  input  logic                  imem_wready,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int          WCW = ADDR_WIDTH + 1;
  localparam logic [15:0] CAP = 16'(2 ** ADDR_WIDTH);

  loader_state_t   state, state_nxt;
  logic            rdy_en;
  logic [7:0]      len_lo;
  logic [WCW-1:0]  n_words;
  logic [WCW-1:0]  word_cnt;
  logic [WCW-1:0]  word_cnt_inc;
  logic [7:0]      csum;
  logic [15:0]     n16;
  logic            len_bad;
  logic            rx_fire;
  logic            wr_fire;
  logic            asm_clear;
  logic            asm_vld;
  logic            word_vld;
  word_t           asm_word;

  // rdy_en keeps rx_ready low for the first cycle after reset is released.
  assign rx_ready     = rdy_en && !reset && (state != WRITE);
  assign rx_fire      = rx_valid && rx_ready;
  assign wr_fire      = imem_we && imem_wready;
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign n16          = {rx_data, len_lo};
  assign len_bad      = (n16 == 16'd0) || (n16 > CAP);
  assign word_cnt_inc = word_cnt + WCW'(1);
  assign asm_clear    = (state == LEN_HI) && rx_fire;
  assign asm_vld      = (state == DATA) && rx_fire;

  loader_word_asm #(
    .NUM_LANES (4),
    .VEC_W     (8)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (asm_clear),
    .in_vld   (asm_vld),
    .in_byte  (rx_data),
    .word     (asm_word),
    .word_vld (word_vld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: byte-driven transitions, plus write acceptance leaving WRITE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (rx_fire && rx_data == MAGIC) state_nxt = LEN_LO;
      LEN_LO: if (rx_fire) state_nxt = LEN_HI;
      LEN_HI: if (rx_fire) state_nxt = len_bad ? ERROR : DATA;
      DATA:   if (word_vld) state_nxt = WRITE;
      WRITE:  if (wr_fire) state_nxt = (word_cnt_inc == n_words) ? CHECK : DATA;
      CHECK:  if (rx_fire) state_nxt = (rx_data == csum) ? DONE : ERROR;
      DONE:   state_nxt = DONE;
      ERROR:  if (rx_fire && rx_data == MAGIC) state_nxt = LEN_LO;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: length, checksum, word counter and the held write request.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_en    <= 1'b0;
      cpu_reset <= 1'b1;
      len_lo    <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      rdy_en    <= 1'b1;
      // Core leaves reset one cycle after DONE is reached.
      cpu_reset <= (state != DONE);
      if (state == LEN_LO && rx_fire) len_lo <= rx_data;
      if (asm_clear) begin
        n_words  <= n16[WCW-1:0];
        word_cnt <= '0;
        csum     <= '0;
      end
      if (asm_vld) csum <= csum ^ rx_data;
      if (word_vld) begin
        imem_we   <= 1'b1;
        imem_addr <= word_cnt[ADDR_WIDTH-1:0];
        imem_data <= asm_word;
      end
      if (wr_fire) begin
        imem_we  <= 1'b0;
        word_cnt <= word_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from the format rules,
// the expected write stream is queued at build time and matched per handshake.
module tb_imem_loader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_wready = 1'b0;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_wready (imem_wready),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         expq[$];
  logic [7:0]  txq[$];
  int          wr_prob = 100;
  int          gap_prob = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory side: optional forced stall on the pending write, else random accept.
  always @(negedge clk) begin
    if (stall_cnt > 0 && imem_we) begin
      imem_wready = 1'b0;
      stall_cnt--;
    end else begin
      imem_wready = (int'($urandom_range(99)) < wr_prob);
    end
  end

  // Per-cycle checker: handshake rules, write stream and release timing.
  logic        pv_we = 1'b0, pv_wr = 1'b0, pv_done = 1'b0;
  logic [AW-1:0] pv_addr = '0;
  logic [31:0] pv_data = '0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      pv_we   = 1'b0;
      pv_wr   = 1'b0;
      pv_done = 1'b0;
    end else begin
      chk("done_and_error", 32'(done && error), 32'd0);
      chk("cpu_reset_follows_done", 32'(cpu_reset), 32'(!pv_done));
      if (pv_we && !pv_wr) begin
        chk("we_held", 32'(imem_we), 32'd1);
        chk("addr_held", 32'(imem_addr), 32'(pv_addr));
        chk("data_held", imem_data, pv_data);
      end
      if (imem_we) chk("rx_ready_while_writing", 32'(rx_ready), 32'd0);
      if (imem_we && !imem_wready) stall_seen++;
      if (imem_we && imem_wready) begin
        last_addr = imem_addr;
        if (expq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = expq.pop_front();
          chk("write_addr", 32'(imem_addr), 32'(e.a));
          chk("write_data", imem_data, e.d);
        end
      end
      pv_we   = imem_we;
      pv_wr   = imem_wready;
      pv_done = done;
      pv_addr = imem_addr;
      pv_data = imem_data;
    end
  end

  // Offer one byte (called on a negedge); returns on the negedge after transfer.
  task automatic send_byte(input logic [7:0] b, input bit want_ready);
    bit ok;
    if (gap_prob > 0)
      while (int'($urandom_range(99)) < gap_prob) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      #1;
      if (want_ready && t == 0) chk("ready_while_dropping", 32'(rx_ready), 32'd1);
      if (rx_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_all();
    while (txq.size() > 0) send_byte(txq.pop_front(), 1'b0);
  endtask

  // Frame builder: expected writes follow directly from N and the payload.
  task automatic build_frame(input int n, input bit bad);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    n16 = 16'(n);
    cs  = '0;
    txq.push_back(8'hA5);
    txq.push_back(n16[7:0]);
    txq.push_back(n16[15:8]);
    if (n >= 1 && n <= 2 ** AW) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int k = 0; k < 4; k++) begin
          txq.push_back(w[8*k +: 8]);
          cs ^= w[8*k +: 8];
        end
        expq.push_back(wr_t'{a: AW'(i), d: w});
      end
      txq.push_back(bad ? (cs ^ 8'h01) : cs);
    end
  endtask

  // Hand-written two-word frame; the payload bytes XOR to 0x90.
  task automatic nominal_frame(input logic [7:0] cs);
    logic [7:0] f[12];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    f[11] = cs;
    foreach (f[i]) txq.push_back(f[i]);
    expq.push_back(wr_t'{a: 9'd0, d: 32'h0000_0013});
    expq.push_back(wr_t'{a: 9'd1, d: 32'h0010_0093});
  endtask

  task automatic check_end(input string nm, input bit exp_done, input bit exp_err);
    #3;
    chk({nm, "_done"}, 32'(done), 32'(exp_done));
    chk({nm, "_error"}, 32'(error), 32'(exp_err));
    chk({nm, "_writes_left"}, 32'(expq.size()), 32'd0);
    @(negedge clk);
    #3;
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    expq.delete();
    txq.delete();
    repeat (2) @(negedge clk);
    #1;
    for (int ph = 0; ph < 2; ph++) begin
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_data", imem_data, 32'd0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      reset = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("ready_after_reset", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g[3];
    // Nominal load with an always-ready memory.
    do_reset();
    nominal_frame(8'h90);
    send_all();
    check_end("nominal", 1'b1, 1'b0);

    // First write held off for 5 cycles.
    do_reset();
    stall_cnt  = 5;
    stall_seen = 0;
    nominal_frame(8'h90);
    send_all();
    check_end("backpressure", 1'b1, 1'b0);
    chk("backpressure_stall_cycles", 32'(stall_seen), 32'd5);

    // Bad checksum, then a good frame straight out of ERROR.
    do_reset();
    nominal_frame(8'h81);
    send_all();
    check_end("bad_csum", 1'b0, 1'b1);
    nominal_frame(8'h90);
    send_all();
    check_end("recover", 1'b1, 1'b0);

    // Length bounds.
    do_reset();
    build_frame(0, 1'b0);
    send_all();
    check_end("len_zero", 1'b0, 1'b1);
    build_frame(513, 1'b0);
    send_all();
    check_end("len_513", 1'b0, 1'b1);
    g = '{8'h00, 8'h5A, 8'hFF};
    foreach (g[i]) send_byte(g[i], 1'b1);
    check_end("error_drops", 1'b0, 1'b1);

    do_reset();
    wr_prob = 70;
    build_frame(512, 1'b0);
    send_all();
    check_end("len_512", 1'b1, 1'b0);
    chk("len_512_last_addr", 32'(last_addr), 32'd511);
    wr_prob = 100;

    // Garbage ahead of MAGIC is dropped while ready stays high.
    do_reset();
    g = '{8'h00, 8'hFF, 8'h13};
    foreach (g[i]) send_byte(g[i], 1'b1);
    nominal_frame(8'h90);
    send_all();
    check_end("garbage", 1'b1, 1'b0);

    // Reset after the 6th byte, then a full load from address 0.
    do_reset();
    nominal_frame(8'h90);
    for (int i = 0; i < 6; i++) send_byte(txq.pop_front(), 1'b0);
    do_reset();
    nominal_frame(8'h90);
    send_all();
    check_end("after_mid_reset", 1'b1, 1'b0);

    // Random frames, random gaps and memory stalls.
    gap_prob = 30;
    wr_prob  = 60;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      bit bad;
      bad = ($urandom_range(3) == 0);
      build_frame(int'($urandom_range(1, 8)), bad);
      send_all();
      check_end("random", !bad, bad);
      if (!bad) begin
        for (int k = 0; k < 2; k++) send_byte(8'($urandom), 1'b1);
        check_end("done_sticky", 1'b1, 1'b0);
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
